// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths and register-address constants, used by the register
// file, the MEM/WB pipeline register and the decode stage.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NREG       = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_file_if.sv
// Writeback bus from the MEM/WB pipeline register into the register file.
interface reg_file_if
  import cpu_pkg::*;
();

  logic      rf_we;
  reg_addr_t rf_waddr;
  xlen_t     rf_wdata;

  modport master (output rf_we, output rf_waddr, output rf_wdata);
  modport slave  (input  rf_we, input  rf_waddr, input  rf_wdata);

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register busy bits for outstanding long-latency results, with
// flush > set > clear priority and two writeback-aware lookups.
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      sb_set,
  input  reg_addr_t sb_addr,
  input  logic      sb_flush,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  output logic      rs1_busy,
  output logic      rs2_busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // NOTE: the set is applied after the clear so that a same-register set wins;
  // busy_d gets its default first so no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    if (sb_flush) begin
      busy_d = '0;
    end else begin
      if (clr_en)
        busy_d[clr_addr] = 1'b0;
      if (sb_set && (sb_addr != REG_ZERO))
        busy_d[sb_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // A writeback landing this cycle resolves the hazard for decode immediately.
  assign rs1_busy = busy_q[rs1_addr] & ~(clr_en && (clr_addr == rs1_addr));
  assign rs2_busy = busy_q[rs2_addr] & ~(clr_en && (clr_addr == rs2_addr));

endmodule

// File: rtl/reg_file.sv
// 32 x XLEN integer register file: two bypassed decode read ports, an
// unbypassed debug port, and the load-hazard scoreboard.
module reg_file
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  reg_file_if.slave  wb,
  input  reg_addr_t  rs1_addr,
  output xlen_t      rs1_data,
  input  reg_addr_t  rs2_addr,
  output xlen_t      rs2_data,
  input  logic       sb_set,
  input  reg_addr_t  sb_addr,
  input  logic       sb_flush,
  output logic       rs1_busy,
  output logic       rs2_busy,
  input  reg_addr_t  dbg_addr,
  output xlen_t      dbg_data
);

  xlen_t regs_q [NREG];
  logic  wr_en;

  assign wr_en = wb.rf_we && (wb.rf_waddr != REG_ZERO);

  // NOTE: this storage is reset on purpose -- a restart must see all-zero
  // architectural state; most RAM-style arrays should not carry a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wb.rf_waddr] <= wb.rf_wdata;
    end
  end

  // Bypass is held off during reset so every read output is zero.
  always_comb begin
    rs1_data = regs_q[rs1_addr];
    rs2_data = regs_q[rs2_addr];
    if (wr_en && !rst && (wb.rf_waddr == rs1_addr)) rs1_data = wb.rf_wdata;
    if (wr_en && !rst && (wb.rf_waddr == rs2_addr)) rs2_data = wb.rf_wdata;
    if (rs1_addr == REG_ZERO) rs1_data = '0;
    if (rs2_addr == REG_ZERO) rs2_data = '0;
  end

  assign dbg_data = regs_q[dbg_addr];

  reg_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .sb_flush (sb_flush),
    .clr_en   (wb.rf_we),
    .clr_addr (wb.rf_waddr),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, reset sequence,
// then randomized traffic against an array-based reference model.
module tb_reg_file;
  import cpu_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  reg_addr_t rs1_addr, rs2_addr, sb_addr, dbg_addr;
  xlen_t     rs1_data, rs2_data, dbg_data;
  logic      sb_set, sb_flush, rs1_busy, rs2_busy;

  int checks = 0;
  int errors = 0;

  reg_file_if wb_if ();

  reg_file dut (
    .clk      (clk),
    .rst      (rst),
    .wb       (wb_if.slave),
    .rs1_addr (rs1_addr),
    .rs1_data (rs1_data),
    .rs2_addr (rs2_addr),
    .rs2_data (rs2_data),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .sb_flush (sb_flush),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic      we;   reg_addr_t wa;  xlen_t wd;
    reg_addr_t r1;   reg_addr_t r2;  reg_addr_t dbg;
    logic      set;  reg_addr_t sa;  logic  flush;
    xlen_t     e_d1; xlen_t e_d2;    xlen_t e_dbg;
    logic      e_b1; logic  e_b2;
  } vec_t;

  vec_t vecs [17];

  // Reference model: architectural state as plain arrays.
  xlen_t m_regs [NREG];
  logic  m_busy [NREG];

  task automatic check(input string name, input xlen_t act, input xlen_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input reg_addr_t wa, input xlen_t wd,
                       input reg_addr_t r1, input reg_addr_t r2, input reg_addr_t dbg,
                       input logic set, input reg_addr_t sa, input logic flush);
    wb_if.rf_we = we; wb_if.rf_waddr = wa; wb_if.rf_wdata = wd;
    rs1_addr = r1; rs2_addr = r2; dbg_addr = dbg;
    sb_set = set; sb_addr = sa; sb_flush = flush;
  endtask

  function automatic vec_t mk(logic we, reg_addr_t wa, xlen_t wd,
                              reg_addr_t r1, reg_addr_t r2, reg_addr_t dbg,
                              logic set, reg_addr_t sa, logic flush,
                              xlen_t d1, xlen_t d2, xlen_t dd, logic b1, logic b2);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.r1 = r1; v.r2 = r2; v.dbg = dbg;
    v.set = set; v.sa = sa; v.flush = flush;
    v.e_d1 = d1; v.e_d2 = d2; v.e_dbg = dd; v.e_b1 = b1; v.e_b2 = b2;
    return v;
  endfunction

  function automatic xlen_t m_read(reg_addr_t a);
    if (a == 0) return '0;
    if (wb_if.rf_we && wb_if.rf_waddr == a) return wb_if.rf_wdata;
    return m_regs[a];
  endfunction

  function automatic logic m_hazard(reg_addr_t a);
    return m_busy[a] && !(wb_if.rf_we && wb_if.rf_waddr == a);
  endfunction

  initial begin
    //            we wa  wd            r1  r2  dbg set sa flush  d1            d2            dbg           b1 b2
    vecs[0]  = mk(1, 7,  32'h12345678, 7,  7,  7,  0, 0, 0,  32'h12345678, 32'h12345678, 32'h0,        0, 0);
    vecs[1]  = mk(0, 0,  32'h0,        7,  0,  7,  0, 0, 0,  32'h12345678, 32'h0,        32'h12345678, 0, 0);
    vecs[2]  = mk(1, 0,  32'hFFFFFFFF, 0,  7,  0,  1, 0, 0,  32'h0,        32'h12345678, 32'h0,        0, 0);
    vecs[3]  = mk(0, 0,  32'h0,        0,  3,  0,  1, 3, 0,  32'h0,        32'h0,        32'h0,        0, 0);
    vecs[4]  = mk(0, 0,  32'h0,        0,  3,  3,  0, 0, 0,  32'h0,        32'h0,        32'h0,        0, 1);
    vecs[5]  = mk(1, 3,  32'hA5,       0,  3,  3,  0, 0, 0,  32'h0,        32'hA5,       32'h0,        0, 0);
    vecs[6]  = mk(0, 0,  32'h0,        0,  3,  3,  0, 0, 0,  32'h0,        32'hA5,       32'hA5,       0, 0);
    vecs[7]  = mk(1, 9,  32'h99,       9,  0,  9,  1, 9, 0,  32'h99,       32'h0,        32'h0,        0, 0);
    vecs[8]  = mk(0, 0,  32'h0,        9,  9,  9,  0, 0, 0,  32'h99,       32'h99,       32'h99,       1, 1);
    vecs[9]  = mk(1, 9,  32'h1234,     9,  4,  9,  1, 4, 0,  32'h1234,     32'h0,        32'h99,       0, 0);
    vecs[10] = mk(0, 0,  32'h0,        4,  9,  9,  0, 0, 0,  32'h0,        32'h1234,     32'h1234,     1, 0);
    vecs[11] = mk(0, 0,  32'h0,        0,  0,  0,  1, 1, 0,  32'h0,        32'h0,        32'h0,        0, 0);
    vecs[12] = mk(0, 0,  32'h0,        1,  0,  0,  1, 2, 0,  32'h0,        32'h0,        32'h0,        1, 0);
    vecs[13] = mk(0, 0,  32'h0,        1,  2,  0,  1, 31, 0, 32'h0,        32'h0,        32'h0,        1, 1);
    vecs[14] = mk(0, 0,  32'h0,        31, 6,  0,  1, 6, 1,  32'h0,        32'h0,        32'h0,        1, 0);
    vecs[15] = mk(0, 0,  32'h0,        31, 6,  0,  0, 0, 0,  32'h0,        32'h0,        32'h0,        0, 0);
    vecs[16] = mk(0, 0,  32'h0,        4,  1,  0,  0, 0, 0,  32'h0,        32'h0,        32'h0,        0, 0);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 5, 31, 5, 0, 0, 0);
    #1;
    check("reset_rs1", rs1_data, '0);
    check("reset_busy2", {31'b0, rs2_busy}, '0);
    rst = 1'b0;

    // Directed table: inputs held for one cycle, outputs sampled before the edge.
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].r1, vecs[i].r2, vecs[i].dbg,
            vecs[i].set, vecs[i].sa, vecs[i].flush);
      #1;
      check($sformatf("vec%0d_rs1_data", i), rs1_data, vecs[i].e_d1);
      check($sformatf("vec%0d_rs2_data", i), rs2_data, vecs[i].e_d2);
      check($sformatf("vec%0d_dbg_data", i), dbg_data, vecs[i].e_dbg);
      check($sformatf("vec%0d_rs1_busy", i), {31'b0, rs1_busy}, {31'b0, vecs[i].e_b1});
      check($sformatf("vec%0d_rs2_busy", i), {31'b0, rs2_busy}, {31'b0, vecs[i].e_b2});
    end

    // Reset mid-run: x5 written and marked busy, then cleared asynchronously.
    @(negedge clk);
    drive(1, 5, 32'hDEADBEEF, 5, 5, 5, 1, 5, 0);
    @(negedge clk);
    drive(0, 0, 0, 5, 5, 5, 0, 0, 0);
    #1;
    check("pre_reset_dbg", dbg_data, 32'hDEADBEEF);
    check("pre_reset_busy", {31'b0, rs1_busy}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("in_reset_rs1", rs1_data, '0);
    check("in_reset_dbg", dbg_data, '0);
    check("in_reset_busy", {31'b0, rs2_busy}, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_rs1", rs1_data, '0);
    check("post_reset_dbg", dbg_data, '0);
    check("post_reset_busy", {31'b0, rs1_busy}, '0);

    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end

    // Randomized traffic on a narrow address window so collisions are common.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      drive($urandom_range(0, 1) == 1, reg_addr_t'($urandom_range(0, 7)), $urandom,
            reg_addr_t'($urandom_range(0, 7)), reg_addr_t'($urandom_range(0, 7)),
            reg_addr_t'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
            reg_addr_t'($urandom_range(0, 7)), $urandom_range(0, 24) == 0);
      #1;
      check("rand_rs1_data", rs1_data, m_read(rs1_addr));
      check("rand_rs2_data", rs2_data, m_read(rs2_addr));
      check("rand_dbg_data", dbg_data, (dbg_addr == 0) ? '0 : m_regs[dbg_addr]);
      check("rand_rs1_busy", {31'b0, rs1_busy}, {31'b0, m_hazard(rs1_addr)});
      check("rand_rs2_busy", {31'b0, rs2_busy}, {31'b0, m_hazard(rs2_addr)});
      if (wb_if.rf_we && wb_if.rf_waddr != 0) m_regs[wb_if.rf_waddr] = wb_if.rf_wdata;
      if (sb_flush) begin
        for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
      end else begin
        if (wb_if.rf_we) m_busy[wb_if.rf_waddr] = 1'b0;
        if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
